// File: rtl/mux_scan.sv
// mux_scan: registered N-channel selector with manual-select and round-robin scan modes.
// Optional build macro MUX_SCAN_SKIP_EN: when defined, scan mode skips idle channels
// (work-conserving round-robin); when undefined, scan waits on the channel at the pointer.
module mux_scan #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 8,
   parameter int SEL_W    = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ack,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_ch,
   output logic                      out_valid,
   input  logic                      out_ready
);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t             r_state;
   logic [WIDTH-1:0]   r_data;
   logic [SEL_W-1:0]   r_ch;
   logic [SEL_W-1:0]   r_ptr;

   logic               w_slot;
   logic               w_found;
   logic               w_capture;
   logic [SEL_W-1:0]   w_idx;
   logic [SEL_W-1:0]   w_idx_next;
   logic [WIDTH-1:0]   w_data;

`ifdef MUX_SCAN_SKIP_EN
   localparam int PW = SEL_W + 1;
   logic [PW-1:0]      w_probe;
`endif

   // Output register can take a beat when empty or when it drains this cycle.
   always_comb begin
      w_slot = (r_state == S_EMPTY) || out_ready;
   end

   // Candidate channel selection for the current mode.
   always_comb begin
      w_found = 1'b0;
      w_idx   = '0;
`ifdef MUX_SCAN_SKIP_EN
      w_probe = '0;
`endif
      if (!mode) begin
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (!w_found && (sel == SEL_W'(k)) && in_valid[k]) begin
               w_found = 1'b1;
               w_idx   = SEL_W'(k);
            end
         end
      end else begin
`ifdef MUX_SCAN_SKIP_EN
         // ptr is always < CHANNELS, so one conditional subtract gives the wrap.
         for (int unsigned i = 0; i < CHANNELS; i++) begin
            w_probe = {1'b0, r_ptr} + PW'(i);
            if (w_probe >= PW'(CHANNELS)) begin
               w_probe = w_probe - PW'(CHANNELS);
            end
            for (int unsigned k = 0; k < CHANNELS; k++) begin
               if (!w_found && (w_probe == PW'(k)) && in_valid[k]) begin
                  w_found = 1'b1;
                  w_idx   = SEL_W'(k);
               end
            end
         end
`else
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (!w_found && (r_ptr == SEL_W'(k)) && in_valid[k]) begin
               w_found = 1'b1;
               w_idx   = SEL_W'(k);
            end
         end
`endif
      end
   end

   // Data mux, capture decision, one-hot acknowledge and next pointer value.
   always_comb begin
      w_data = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (w_idx == SEL_W'(k)) begin
            w_data = in_data[k*WIDTH +: WIDTH];
         end
      end
      w_capture = w_slot && w_found && !rst;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         in_ack[k] = w_capture && (w_idx == SEL_W'(k));
      end
      w_idx_next = (w_idx == SEL_W'(CHANNELS - 1)) ? '0 : w_idx + SEL_W'(1);
   end

   // EMPTY/FULL state machine with the output register and scan pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_EMPTY;
         r_data  <= '0;
         r_ch    <= '0;
         r_ptr   <= '0;
      end else if (w_capture) begin
         r_state <= S_FULL;
         r_data  <= w_data;
         r_ch    <= w_idx;
         if (mode) begin
            r_ptr <= w_idx_next;
         end
      end else if ((r_state == S_FULL) && out_ready) begin
         r_state <= S_EMPTY;
      end
   end

   assign out_valid = (r_state == S_FULL);
   assign out_data  = r_data;
   assign out_ch    = r_ch;

endmodule

// File: tb/tb_mux_scan.sv
// Self-checking bench for mux_scan (CHANNELS=8, WIDTH=8, SEL_W=4).
// Expected beats are queued when an acknowledge is expected and popped when consumed.
module tb_mux_scan;

   localparam int WIDTH    = 8;
   localparam int CHANNELS = 8;
   localparam int SEL_W    = 4;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      mode;
   logic [SEL_W-1:0]          sel;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS-1:0]       in_ack;
   logic [WIDTH-1:0]          out_data;
   logic [SEL_W-1:0]          out_ch;
   logic                      out_valid;
   logic                      out_ready;

   logic [WIDTH-1:0]          chdata [CHANNELS];

   typedef struct {
      logic [SEL_W-1:0] ch;
      logic [WIDTH-1:0] data;
   } beat_t;

   beat_t sb[$];
   int    n_cmp  = 0;
   int    n_fail = 0;

   always #5 clk = ~clk;

   always_comb begin
      in_data = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         in_data[k*WIDTH +: WIDTH] = chdata[k];
      end
   end

   mux_scan #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS),
      .SEL_W    (SEL_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ack    (in_ack),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One cycle: check ack/valid before the edge, score any consumed beat, queue any new one.
   task automatic tick(input string tag, input logic [CHANNELS-1:0] exp_ack, input logic exp_valid);
      beat_t b;
      @(negedge clk);
      chk({tag, "/ack"}, 32'(in_ack), 32'(exp_ack));
      chk({tag, "/valid"}, 32'(out_valid), 32'(exp_valid));
      if (out_valid && out_ready) begin
         chk({tag, "/sb_has_beat"}, 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            b = sb.pop_front();
            chk({tag, "/out_ch"}, 32'(out_ch), 32'(b.ch));
            chk({tag, "/out_data"}, 32'(out_data), 32'(b.data));
         end
      end
      for (int k = 0; k < CHANNELS; k++) begin
         if (exp_ack[k]) begin
            b.ch   = SEL_W'(k);
            b.data = chdata[k];
            sb.push_back(b);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      mode      = 1'b1;
      sel       = '0;
      out_ready = 1'b1;
      in_valid  = 8'hFF;
      for (int k = 0; k < CHANNELS; k++) begin
         chdata[k] = 8'h10 + 8'(k);
      end
      @(posedge clk);
      #1;

      // Reset held with every channel valid: no ack, outputs cleared.
      tick("rst0", 8'h00, 1'b0);
      chk("rst0/out_data", 32'(out_data), 32'h0);
      chk("rst0/out_ch", 32'(out_ch), 32'h0);
      tick("rst1", 8'h00, 1'b0);
      chk("rst1/out_data", 32'(out_data), 32'h0);
      chk("rst1/out_ch", 32'(out_ch), 32'h0);
      rst = 1'b0;

      // Scan at full rate: channels 0..7 then wrap to 0.
      for (int i = 0; i < 9; i++) begin
         tick("scan", 8'(1 << (i % 8)), (i != 0));
      end

      // Manual select of channel 5.
      mode      = 1'b0;
      sel       = 4'd5;
      chdata[5] = 8'hA5;
      for (int i = 0; i < 3; i++) begin
         tick("man5", 8'h20, 1'b1);
      end

      // Manual select of channel 3, then backpressure.
      sel       = 4'd3;
      chdata[3] = 8'h3C;
      tick("man3", 8'h08, 1'b1);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick("bp", 8'h00, 1'b1);
         chk("bp/out_data", 32'(out_data), 32'h3C);
         chk("bp/out_ch", 32'(out_ch), 32'd3);
      end
      out_ready = 1'b1;
      tick("refill", 8'h08, 1'b1);

      // Out-of-range select never captures; register drains.
      sel = 4'd9;
      tick("sel9", 8'h00, 1'b1);
      tick("sel9_empty", 8'h00, 1'b0);

      // Reset while FULL under backpressure; scan pointer was left at 1.
      mode      = 1'b1;
      in_valid  = 8'hFF;
      out_ready = 1'b0;
      tick("pre_rst", 8'h02, 1'b0);
      tick("hold", 8'h00, 1'b1);
      rst = 1'b1;
      tick("midrst", 8'h00, 1'b1);
      sb.delete();
      rst = 1'b0;
      chk("midrst/out_data", 32'(out_data), 32'h0);
      chk("midrst/out_ch", 32'(out_ch), 32'h0);

      in_valid  = 8'b1000_0100;
      out_ready = 1'b1;
`ifdef MUX_SCAN_SKIP_EN
      tick("skip_a", 8'h04, 1'b0);
      tick("skip_b", 8'h80, 1'b1);
      tick("skip_c", 8'h04, 1'b1);
      tick("skip_d", 8'h80, 1'b1);
      in_valid = 8'h00;
      tick("drain", 8'h00, 1'b1);
      tick("idle", 8'h00, 1'b0);
`else
      for (int i = 0; i < 3; i++) begin
         tick("strict_wait", 8'h00, 1'b0);
      end
      in_valid = 8'b1000_0101;
      tick("strict_ch0", 8'h01, 1'b0);
      in_valid = 8'b1000_0100;
      tick("strict_wait1", 8'h00, 1'b1);
      in_valid = 8'h00;
      tick("idle", 8'h00, 1'b0);
`endif

      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mux_scan.md
# mux_scan

Parametrised, registered N-channel multiplexer with a manual-select mode and a round-robin scan mode. It picks one W-bit beat per cycle from CHANNELS valid-qualified inputs, acknowledges the source channel and presents the beat on a valid/ready output register. It generalises the team's fixed 2:1 and 8:1 combinational mux cells into a pipelined channel selector for lab datapaths that merge several producers onto one consumer.

## Interface
- WIDTH, 8, data bits per channel
- CHANNELS, 8, number of input channels (≥2, need not be a power of 2)
- SEL_W, 3, select/pointer width; must satisfy 2^SEL_W ≥ CHANNELS
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- mode  input  1  0 = manual select, 1 = round-robin scan
- sel  input  SEL_W  channel to take in manual mode
- in_data  input  CHANNELS*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel data valid
- in_ack  output  CHANNELS  one-hot pulse; channel consumed this cycle
- out_data  output  WIDTH  registered selected beat
- out_ch  output  SEL_W  index of channel that produced out_data
- out_valid  output  1  output register holds a beat
- out_ready  input  1  consumer accepts beat when out_valid & out_ready

## Operation
- Two states: EMPTY (out_valid=0), FULL (out_valid=1).
- Capture allowed ("slot") when EMPTY, or FULL with out_ready=1 (drain and refill in same cycle).
- Manual mode: candidate = sel; capture iff slot & sel < CHANNELS & in_valid[sel]. sel ≥ CHANNELS never captures, no ack.
- Scan mode: pointer ptr (reset 0). Candidate = first k with in_valid[k] set, searching ptr, ptr+1, …, wrapping CHANNELS-1 → 0 (behaviour with MUX_SCAN_SKIP_EN undefined: see Configuration).
- On capture of channel k: out_data ← in_data[k], out_ch ← k, out_valid ← 1, in_ack[k]=1 (combinational, same cycle), ptr ← (k+1) mod CHANNELS in scan mode; ptr unchanged in manual mode.
- No capture while FULL and out_ready=0; register and out_valid hold, in_ack all 0.
- FULL & out_ready & no candidate → EMPTY.
- mode/sel may change any cycle; take effect on the next capture decision; ptr retained across mode switches.
- in_ack is at most one-hot; never asserted for a channel whose in_valid is 0.
- Reset mid-operation: held beat discarded, no ack in reset cycle.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, ptr=0, in_ack=0.
- Latency: in_valid[k] sampled at edge n → out_valid/out_data at edge n (visible cycle n+1); 1 cycle.
- Throughput: 1 beat/cycle with out_ready held high.
- in_ack combinational from registered state and inputs; no combinational path from out_ready to out_data.
- Producer must hold in_data/in_valid until in_ack.

## Configuration
- MUX_SCAN_SKIP_EN defined: scan mode searches from ptr and skips channels with in_valid=0 (work-conserving round-robin, as above).
- Not defined: scan mode is strict sequential; candidate is only channel ptr; if in_valid[ptr]=0 nothing is captured and ptr does not advance (waits). Manual mode identical in both builds.

## Test plan
- Reset: assert rst 2 cycles with all in_valid=1 → out_valid=0, out_data=0, out_ch=0, in_ack=0 throughout; first capture after release is channel 0 in scan mode.
- Manual: mode=0, sel=5, in_data ch5=0xA5, in_valid=8'hFF, out_ready=1 → in_ack=8'h20 every cycle, out_data=0xA5, out_ch=5, one beat/cycle; sel=9 (CHANNELS=8, SEL_W=4 build) → no ack, out_valid drops after drain.
- Scan full rate: mode=1, in_valid=8'hFF, ch k data = 0x10+k, out_ready=1 → out_ch sequence 0,1,…,7,0; out_data 0x10…0x17; wrap verified.
- Skip (SKIP_EN): in_valid=8'b1000_0100 → out_ch alternates 2,7,2,7; without SKIP_EN → captures stall at ptr=0 until in_valid[0] raised.
- Backpressure: out_ready=0 for 3 cycles while FULL with ch3=0x3C → out_data stays 0x3C, in_ack=0; out_ready=1 → drain and refill same cycle, no beat lost or duplicated.
- Mid-op reset: rst during FULL with out_ready=0 → out_valid=0 next cycle, ptr=0, no ack issued.
